// File: rtl/spi_slave_if.sv
// Pin-level and byte-level signals of one SPI slave endpoint.
// The slave modport is the endpoint's view; the master modport is the surroundings.
interface spi_slave_if;
   logic [7:0] i_TX_Byte;
   logic       i_TX_DV;
   logic       o_TX_Ready;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       i_SPI_Clk;
   logic       i_SPI_MOSI;
   logic       i_SPI_CS_n;
   logic       o_SPI_MISO;

   modport slave (
      input  i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
      output o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_MISO
   );

   modport master (
      output i_TX_Byte, i_TX_DV, i_SPI_Clk, i_SPI_MOSI, i_SPI_CS_n,
      input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_MISO
   );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint, modes 0-3, all pins oversampled in the i_Clk domain.
// Optional SPI_SLAVE_MISO_TRISTATE_EN: MISO floats while chip select is high.
module spi_slave #(
   parameter int SPI_MODE = 0
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   spi_slave_if.slave  bus
);
   localparam bit CPOL = SPI_MODE[1];
   localparam bit CPHA = SPI_MODE[0];

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   // [1] is the synchronized SCK, [2] its previous value for edge detection
   logic [2:0] sck_pipe_q,  sck_pipe_d;
   logic [1:0] mosi_pipe_q, mosi_pipe_d;
   logic [1:0] cs_pipe_q,   cs_pipe_d;

   state_t     state_q,      state_d;
   logic [2:0] rx_cnt_q,     rx_cnt_d;
   logic [6:0] rx_shift_q,   rx_shift_d;
   logic [7:0] rx_byte_q,    rx_byte_d;
   logic       rx_dv_q,      rx_dv_d;
   logic [2:0] tx_cnt_q,     tx_cnt_d;
   logic [7:0] tx_byte_q,    tx_byte_d;
   logic [7:0] hold_q,       hold_d;
   logic       hold_full_q,  hold_full_d;
   logic       wait_start_q, wait_start_d;

   logic sck_sync, sck_prev, mosi_sync, cs_sync;
   logic leading_edge, trailing_edge, sample_edge, shift_edge;
   logic load;
   logic miso_bit;

   assign sck_sync  = sck_pipe_q[1];
   assign sck_prev  = sck_pipe_q[2];
   assign mosi_sync = mosi_pipe_q[1];
   assign cs_sync   = cs_pipe_q[1];

   assign leading_edge  = (sck_prev == CPOL) && (sck_sync != CPOL);
   assign trailing_edge = (sck_prev != CPOL) && (sck_sync == CPOL);
   assign sample_edge   = CPHA ? trailing_edge : leading_edge;
   assign shift_edge    = CPHA ? leading_edge  : trailing_edge;

   always_comb begin
      sck_pipe_d   = {sck_pipe_q[1:0], bus.i_SPI_Clk};
      mosi_pipe_d  = {mosi_pipe_q[0], bus.i_SPI_MOSI};
      cs_pipe_d    = {cs_pipe_q[0], bus.i_SPI_CS_n};
      state_d      = state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_shift_d   = rx_shift_q;
      rx_byte_d    = rx_byte_q;
      rx_dv_d      = 1'b0;
      tx_cnt_d     = tx_cnt_q;
      tx_byte_d    = tx_byte_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      wait_start_d = wait_start_q;
      load         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!cs_sync) begin
               state_d      = S_ACTIVE;
               rx_cnt_d     = 3'd0;
               tx_cnt_d     = 3'd0;
               rx_shift_d   = 7'd0;
               // CPHA=0 must present the MSB before the first SCK edge
               load         = !CPHA;
               wait_start_d = CPHA;
            end
         end
         S_ACTIVE: begin
            if (cs_sync) begin
               state_d      = S_IDLE;
               rx_cnt_d     = 3'd0;
               tx_cnt_d     = 3'd0;
               rx_shift_d   = 7'd0;
               tx_byte_d    = 8'h00;
               wait_start_d = 1'b1;
            end else begin
               if (sample_edge) begin
                  rx_shift_d = {rx_shift_q[5:0], mosi_sync};
                  if (rx_cnt_q == 3'd7) begin
                     rx_byte_d = {rx_shift_q, mosi_sync};
                     rx_dv_d   = 1'b1;
                     rx_cnt_d  = 3'd0;
                  end else begin
                     rx_cnt_d  = rx_cnt_q + 3'd1;
                  end
               end
               if (shift_edge) begin
                  if (tx_cnt_q == 3'd7 || (CPHA && wait_start_q)) begin
                     tx_cnt_d     = 3'd0;
                     load         = 1'b1;
                     wait_start_d = 1'b0;
                  end else begin
                     tx_cnt_d     = tx_cnt_q + 3'd1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         tx_byte_d   = hold_full_q ? hold_q : 8'h00;
         hold_full_d = 1'b0;
      end
      // Evaluated after the load so a write into an empty register survives a same-cycle load
      if (bus.i_TX_DV && !hold_full_q) begin
         hold_d      = bus.i_TX_Byte;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sck_pipe_q   <= {3{CPOL}};
         mosi_pipe_q  <= 2'b00;
         cs_pipe_q    <= 2'b11;
         state_q      <= S_IDLE;
         rx_cnt_q     <= 3'd0;
         rx_shift_q   <= 7'd0;
         rx_byte_q    <= 8'h00;
         rx_dv_q      <= 1'b0;
         tx_cnt_q     <= 3'd0;
         tx_byte_q    <= 8'h00;
         hold_q       <= 8'h00;
         hold_full_q  <= 1'b0;
         wait_start_q <= 1'b1;
      end else begin
         sck_pipe_q   <= sck_pipe_d;
         mosi_pipe_q  <= mosi_pipe_d;
         cs_pipe_q    <= cs_pipe_d;
         state_q      <= state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_shift_q   <= rx_shift_d;
         rx_byte_q    <= rx_byte_d;
         rx_dv_q      <= rx_dv_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_byte_q    <= tx_byte_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         wait_start_q <= wait_start_d;
      end
   end

   assign miso_bit       = tx_byte_q[~tx_cnt_q];
   assign bus.o_TX_Ready = !hold_full_q;
   assign bus.o_RX_DV    = rx_dv_q;
   assign bus.o_RX_Byte  = rx_byte_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   assign bus.o_SPI_MISO = cs_sync ? 1'bz : ((state_q == S_ACTIVE) ? miso_bit : 1'b1);
`else
   assign bus.o_SPI_MISO = (state_q == S_ACTIVE && !cs_sync) ? miso_bit : 1'b1;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// One slave per SPI mode driven by a behavioural SPI master; a byte-level model of the
// holding register predicts every MISO byte and the TX ready flag.
module tb_spi_slave;
   localparam int H = 4;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   localparam logic MISO_IDLE = 1'bz;
`else
   localparam logic MISO_IDLE = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_byte_b;
   logic [3:0] tx_dv;
   logic [3:0] cs_n;
   logic       sck_raw;
   logic       mosi;

   logic [3:0] miso_w, ready_w, rx_dv_w;
   logic [7:0] rx_byte_w [4];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] tx_data [4];
   logic [7:0] wr_data [4];
   logic [3:0] wr_mask;
   logic [7:0] mrx [4];
   logic       hold_full_m [4];
   logic [7:0] hold_val_m [4];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mode
         localparam bit CPOL_G = (gi >= 2);
         spi_slave_if bus ();
         assign bus.i_TX_Byte  = tx_byte_b;
         assign bus.i_TX_DV    = tx_dv[gi];
         assign bus.i_SPI_Clk  = sck_raw ^ CPOL_G;
         assign bus.i_SPI_MOSI = mosi;
         assign bus.i_SPI_CS_n = cs_n[gi];
         assign miso_w[gi]     = bus.o_SPI_MISO;
         assign ready_w[gi]    = bus.o_TX_Ready;
         assign rx_dv_w[gi]    = bus.o_RX_DV;
         assign rx_byte_w[gi]  = bus.o_RX_Byte;
         spi_slave #(.SPI_MODE(gi)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));
      end
   endgenerate

   // Every cycle of o_RX_DV high is logged, so a stretched pulse shows up as an extra byte
   always @(negedge clk) begin
      for (int j = 0; j < 4; j++)
         if (rx_dv_w[j] === 1'b1) rx_q.push_back(rx_byte_w[j]);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_load(input int m);
      exp_q.push_back(hold_full_m[m] ? hold_val_m[m] : 8'h00);
      hold_full_m[m] = 1'b0;
   endtask

   // Takes one clock; a write while the register is occupied must leave it untouched
   task automatic host_write(input int m, input logic [7:0] val);
      tx_byte_b = val;
      tx_dv[m]  = 1'b1;
      if (!hold_full_m[m]) begin
         hold_full_m[m] = 1'b1;
         hold_val_m[m]  = val;
      end
      @(negedge clk);
      tx_dv[m] = 1'b0;
      check("ready_after_write", ready_w[m], !hold_full_m[m]);
   endtask

   task automatic run_frame(input int m, input int nbytes, input int abort_bits, input bit rst_mid);
      bit         cpha;
      int         total;
      int         exp_rx;
      logic [7:0] got;
      cpha  = m[0];
      total = (abort_bits != 0) ? abort_bits : nbytes * 8;
      got   = 8'h00;
      rx_q.delete();
      exp_q.delete();
      cs_n[m] = 1'b0;
      mosi    = tx_data[0][7];
      if (!cpha) model_load(m);
      wait_clks(H);
      for (int k = 0; k < total; k++) begin
         int b = k / 8;
         int i = 7 - (k % 8);
         if (!cpha) begin
            got[i]  = miso_w[m];
            sck_raw = 1'b1;
         end else begin
            if (i == 7) model_load(m);
            sck_raw = 1'b1;
            mosi    = tx_data[b][i];
         end
         if (i == 4 && wr_mask[b]) begin
            host_write(m, wr_data[b]);
            wait_clks(H - 1);
         end else begin
            wait_clks(H);
         end
         if (!cpha) begin
            sck_raw = 1'b0;
            if (k + 1 < total) mosi = tx_data[(k + 1) / 8][7 - ((k + 1) % 8)];
            if (i == 0) model_load(m);
         end else begin
            got[i]  = miso_w[m];
            sck_raw = 1'b0;
         end
         wait_clks(H);
         if (i == 0) begin
            mrx[b] = got;
            check("ready_byte_end", ready_w[m], !hold_full_m[m]);
         end
      end
      if (rst_mid) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         for (int j = 0; j < 4; j++) hold_full_m[j] = 1'b0;
         check("rst_ready", ready_w[m], 1'b1);
         check("rst_rx_dv", rx_dv_w[m], 1'b0);
         check("rst_rx_byte", rx_byte_w[m], 8'h00);
         check("rst_miso", miso_w[m], MISO_IDLE);
      end
      cs_n[m] = 1'b1;
      wait_clks(10);
      exp_rx = (abort_bits != 0) ? abort_bits / 8 : nbytes;
      check("rx_count", 8'(rx_q.size()), 8'(exp_rx));
      for (int b = 0; b < exp_rx && b < rx_q.size(); b++) check("rx_byte", rx_q[b], tx_data[b]);
      if (abort_bits == 0)
         for (int b = 0; b < nbytes; b++) check("miso_byte", mrx[b], exp_q[b]);
      check("ready_end", ready_w[m], !hold_full_m[m]);
      check("miso_idle", miso_w[m], MISO_IDLE);
      $display("[TB] frame mode=%0d bytes=%0d abort_bits=%0d rst=%0d rx=%0d", m, nbytes, abort_bits, rst_mid, rx_q.size());
   endtask

   initial begin
      rst       = 1'b1;
      cs_n      = 4'hF;
      sck_raw   = 1'b0;
      mosi      = 1'b0;
      tx_dv     = 4'h0;
      tx_byte_b = 8'h00;
      wr_mask   = 4'h0;
      for (int j = 0; j < 4; j++) begin
         hold_full_m[j] = 1'b0;
         hold_val_m[j]  = 8'h00;
         tx_data[j]     = 8'h00;
         wr_data[j]     = 8'h00;
         mrx[j]         = 8'h00;
      end
      wait_clks(3);
      for (int j = 0; j < 4; j++) begin
         check("reset_ready", ready_w[j], 1'b1);
         check("reset_rx_dv", rx_dv_w[j], 1'b0);
         check("reset_rx_byte", rx_byte_w[j], 8'h00);
         check("reset_miso", miso_w[j], MISO_IDLE);
      end
      rst = 1'b0;
      wait_clks(4);

      // Mode 0 single byte
      host_write(0, 8'h3C);
      tx_data[0] = 8'hC1;
      run_frame(0, 1, 0, 1'b0);
      check("t1_master_rx", mrx[0], 8'h3C);
      check("t1_slave_rx", rx_byte_w[0], 8'hC1);

      // Mode 0, two bytes with only one preloaded
      host_write(0, 8'hA5);
      tx_data[0] = 8'hBE;
      tx_data[1] = 8'hEF;
      run_frame(0, 2, 0, 1'b0);
      check("t2_master_rx0", mrx[0], 8'hA5);
      check("t2_master_rx1", mrx[1], 8'h00);

      // Mode 3, second byte written during the first
      host_write(3, 8'h81);
      wr_mask    = 4'b0001;
      wr_data[0] = 8'h7E;
      tx_data[0] = 8'h55;
      tx_data[1] = 8'hAA;
      run_frame(3, 2, 0, 1'b0);
      check("t3_master_rx0", mrx[0], 8'h81);
      check("t3_master_rx1", mrx[1], 8'h7E);
      check("t3_slave_rx", rx_byte_w[3], 8'hAA);

      // Mode 0 abort after 5 SCK cycles; the write made mid-byte must survive
      wr_mask    = 4'b0001;
      wr_data[0] = 8'h77;
      tx_data[0] = 8'hF0;
      run_frame(0, 1, 5, 1'b0);
      check("t4_ready_kept", ready_w[0], 1'b0);
      wr_mask    = 4'b0000;
      tx_data[0] = 8'h12;
      run_frame(0, 1, 0, 1'b0);
      check("t4_slave_rx", rx_byte_w[0], 8'h12);
      check("t4_master_rx", mrx[0], 8'h77);

      // Mode 3 reset mid-byte with a byte waiting in the holding register
      host_write(3, 8'h99);
      wr_mask    = 4'b0001;
      wr_data[0] = 8'h66;
      tx_data[0] = 8'h3A;
      run_frame(3, 1, 4, 1'b1);

      for (int f = 0; f < 40; f++) begin
         int m  = $urandom_range(0, 3);
         int nb = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) host_write(m, 8'($urandom));
         if ($urandom_range(0, 3) == 0) host_write(m, 8'($urandom));
         wr_mask = 4'($urandom);
         for (int j = 0; j < 4; j++) begin
            tx_data[j] = 8'($urandom);
            wr_data[j] = 8'($urandom);
         end
         run_frame(m, nb, 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (target) endpoint for the SPI master: receives MOSI bytes and returns MISO bytes, MSB first, in the same SPI mode as the master.
- All SPI pins are sampled in the single system clock domain; no logic is clocked by SCK.
- Byte-level handshake to user logic: a preloaded TX byte with a ready flag, and an RX byte with a one-cycle valid pulse.
- Target: FPGA SPI peripheral; a master-to-slave loopback bench.

Parameters:
- SPI_MODE, 0, SPI mode 0-3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].

Ports:
- i_Clk  in  1  system clock; SCK must be at most i_Clk/8.
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_Byte  in  8  next byte to return on MISO.
- i_TX_DV  in  1  single-cycle write strobe for i_TX_Byte.
- o_TX_Ready  out  1  high when the TX holding register is empty.
- o_RX_DV  out  1  one-cycle pulse: o_RX_Byte valid.
- o_RX_Byte  out  8  last complete byte received.
- i_SPI_Clk  in  1  SCK from master.
- i_SPI_MOSI  in  1  MOSI.
- i_SPI_CS_n  in  1  chip select, active low.
- o_SPI_MISO  out  1  MISO.

Behaviour:
- Reset values (i_Rst = 1 sampled at posedge i_Clk): o_TX_Ready = 1, o_RX_DV = 0, o_RX_Byte = 0x00, o_SPI_MISO = 1, holding register empty, counters 0.
- Synchronizer reset values: SCK = CPOL, CS_n = 1, MOSI = 0.
- Reset applied mid-transfer aborts the byte with no o_RX_DV pulse.
- Synchronizers: 2-flop synchronizers on SCK, MOSI and CS_n. Edges are detected on the synchronized SCK using one further flop.
- Edge definitions:
  - leading edge = SCK transition away from CPOL; trailing edge = transition back to CPOL.
  - sample edge = leading if CPHA = 0, trailing if CPHA = 1.
  - shift edge = the other one.
- Edges are ignored while synchronized CS_n = 1.
- States:
  - IDLE: CS_n high. CS_n falling moves to ACTIVE with rx_cnt = 0, tx_cnt = 0.
  - ACTIVE: CS_n rising returns to IDLE from any bit position.
- RX path:
  - On each sample edge, shift MOSI into the RX shift register LSB side; rx_cnt increments.
  - On the 8th sample edge: o_RX_Byte takes the full byte, o_RX_DV pulses high for exactly 1 cycle, rx_cnt wraps to 0.
  - Latency: o_RX_DV rises 3 i_Clk cycles after the 8th sample edge at the pin (2 sync + 1 register).
- TX holding register:
  - Written when i_TX_DV = 1 and o_TX_Ready = 1; o_TX_Ready then drops on the next cycle.
  - i_TX_DV while o_TX_Ready = 0 is ignored and the holding register is unchanged.
- TX byte load: at each byte start the active TX byte is loaded from the holding register, which sets o_TX_Ready = 1. If the holding register is empty, 0x00 is loaded instead.
- TX load/write collision: if a load and an i_TX_DV write coincide while the holding register is empty, the load takes 0x00 and the write is accepted into the holding register.
- MISO drives bit (7 - tx_cnt) of the active TX byte.
- CPHA = 0 timing:
  - Byte start = CS_n falling; MSB is driven before the first leading edge.
  - Each trailing edge increments tx_cnt. The 8th trailing edge wraps tx_cnt to 0 and performs the next byte start.
- CPHA = 1 timing:
  - The first leading edge of a byte is the byte start (load, MSB driven).
  - Subsequent leading edges increment tx_cnt.
- CS_n rising mid-byte:
  - Partial RX bits are discarded; no o_RX_DV pulse.
  - The active TX byte is discarded; the holding register and o_TX_Ready are preserved.
  - Counters clear and o_SPI_MISO returns to 1.
- Back-to-back bytes are supported without CS_n deassertion.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: o_SPI_MISO is 1'bz whenever synchronized CS_n = 1 (including reset), allowing multiple slaves on a shared MISO.
- Undefined: o_SPI_MISO is driven 1 while idle, as specified above.

Test Plan:
- Mode 0, CLKS_PER_HALF_BIT = 4: preload 0x3C; master sends 0xC1 -> slave o_RX_Byte = 0xC1 with one o_RX_DV pulse; master receives 0x3C; o_TX_Ready returns to 1 at byte start.
- Mode 0, one CS frame: preload 0xA5 only; master sends 0xBE then 0xEF -> slave RX 0xBE, 0xEF (2 pulses); master receives 0xA5, 0x00.
- Mode 3: preload 0x81, then write 0x7E when ready -> master sends 0x55, 0xAA; slave RX 0x55, 0xAA; master receives 0x81, 0x7E.
- CS_n raised after 5 SCK cycles of 0xF0 -> no o_RX_DV. A following full transfer of 0x12 -> o_RX_Byte = 0x12 and o_SPI_MISO idle = 1.
- i_Rst pulsed 1 cycle mid-byte with 0x99 preloaded -> all outputs at reset values; o_TX_Ready = 1; no o_RX_DV for the aborted byte.
- With SPI_SLAVE_MISO_TRISTATE_EN: o_SPI_MISO = z while CS_n = 1 and driven during the frame. Without the macro: o_SPI_MISO = 1 while CS_n = 1.
